// File: rtl/alu_pkg.sv
// Shared constants, opcodes and FSM state type for the two-requester ALU arbiter.
package alu_pkg;

    localparam int unsigned N_BITS_DEF = 32'd6;
    localparam int unsigned LAT_CNT_W  = 32'd3;

    localparam int unsigned OP_ADD   = 32'd0;
    localparam int unsigned OP_SUB   = 32'd1;
    localparam int unsigned OP_AND   = 32'd2;
    localparam int unsigned OP_OR    = 32'd3;
    localparam int unsigned OP_XOR   = 32'd4;
    localparam int unsigned OP_PASSA = 32'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection; the pointer names the requester granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // One-hot grant: a lone requester always wins, a tie goes to the one not served last.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (req)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                if (last) begin
                    grant     = 2'b01;
                    grant_idx = 1'b0;
                end else begin
                    grant     = 2'b10;
                    grant_idx = 1'b1;
                end
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional saturating grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned N_BITS  = N_BITS_DEF,
    parameter int unsigned ALU_LAT = 32'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req0_valid,
    output logic              o_req0_ready,
    input  logic [N_BITS-1:0] i_req0_a,
    input  logic [N_BITS-1:0] i_req0_b,
    input  logic [N_BITS-1:0] i_req0_op,
    input  logic              i_req1_valid,
    output logic              o_req1_ready,
    input  logic [N_BITS-1:0] i_req1_a,
    input  logic [N_BITS-1:0] i_req1_b,
    input  logic [N_BITS-1:0] i_req1_op,
    output logic              o_rsp0_valid,
    output logic [N_BITS-1:0] o_rsp0_res,
    output logic              o_rsp1_valid,
    output logic [N_BITS-1:0] o_rsp1_res,
    output logic [N_BITS-1:0] o_alu_a,
    output logic [N_BITS-1:0] o_alu_b,
    output logic [N_BITS-1:0] o_alu_op,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic              o_busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]        o_grant_cnt0,
    output logic [7:0]        o_grant_cnt1
`endif
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(ALU_LAT);

    arb_state_t           state_r;
    logic [LAT_CNT_W-1:0] cnt_r;
    logic                 last_r;
    logic                 owner_r;
    logic                 busy_r;
    logic [N_BITS-1:0]    alu_a_r;
    logic [N_BITS-1:0]    alu_b_r;
    logic [N_BITS-1:0]    alu_op_r;
    logic                 rsp0_valid_r;
    logic                 rsp1_valid_r;
    logic [N_BITS-1:0]    rsp0_res_r;
    logic [N_BITS-1:0]    rsp1_res_r;

    logic [1:0]           req_s;
    logic [1:0]           grant_s;
    logic                 grant_idx_s;
    logic                 accept_s;
    logic                 handshake_s;
    logic [N_BITS-1:0]    sel_a_s;
    logic [N_BITS-1:0]    sel_b_s;
    logic [N_BITS-1:0]    sel_op_s;

    assign req_s = {i_req1_valid, i_req0_valid};

    rr_arb2 u_rr_arb2 (
        .req       (req_s),
        .last      (last_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Readies are combinational so a request can be taken in its first idle cycle.
    assign accept_s    = (state_r == IDLE) && !reset;
    assign handshake_s = accept_s && (grant_s != 2'b00);

    // Ready decode: only the granted requester, and only while idle and out of reset.
    always_comb begin
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        if (accept_s) begin
            o_req0_ready = grant_s[0];
            o_req1_ready = grant_s[1];
        end else begin
            o_req0_ready = 1'b0;
            o_req1_ready = 1'b0;
        end
    end

    // Operand mux feeding the ALU input registers.
    always_comb begin
        sel_a_s  = i_req0_a;
        sel_b_s  = i_req0_b;
        sel_op_s = i_req0_op;
        if (grant_idx_s) begin
            sel_a_s  = i_req1_a;
            sel_b_s  = i_req1_b;
            sel_op_s = i_req1_op;
        end else begin
            sel_a_s  = i_req0_a;
            sel_b_s  = i_req0_b;
            sel_op_s = i_req0_op;
        end
    end

    // Control FSM with its latency counter, grant pointer and all output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            last_r       <= 1'b1;
            owner_r      <= 1'b0;
            busy_r       <= 1'b0;
            alu_a_r      <= '0;
            alu_b_r      <= '0;
            alu_op_r     <= '0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_res_r   <= '0;
            rsp1_res_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                    if (handshake_s) begin
                        state_r  <= EXEC;
                        busy_r   <= 1'b1;
                        cnt_r    <= LAT_INIT;
                        owner_r  <= grant_idx_s;
                        last_r   <= grant_idx_s;
                        alu_a_r  <= sel_a_s;
                        alu_b_r  <= sel_b_s;
                        alu_op_r <= sel_op_s;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                EXEC: begin
                    // The counter reaching zero marks the cycle the ALU result is valid.
                    if (cnt_r == '0) begin
                        state_r <= RESP;
                        if (owner_r) begin
                            rsp1_res_r   <= i_alu_res;
                            rsp1_valid_r <= 1'b1;
                        end else begin
                            rsp0_res_r   <= i_alu_res;
                            rsp0_valid_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r - LAT_CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    rsp0_valid_r <= 1'b0;
                    rsp1_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_alu_a      = alu_a_r;
    assign o_alu_b      = alu_b_r;
    assign o_alu_op     = alu_op_r;
    assign o_rsp0_valid = rsp0_valid_r;
    assign o_rsp1_valid = rsp1_valid_r;
    assign o_rsp0_res   = rsp0_res_r;
    assign o_rsp1_res   = rsp1_res_r;
    assign o_busy       = busy_r;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt0_r;
    logic [7:0] grant_cnt1_r;

    // Saturating per-requester handshake counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt0_r <= 8'd0;
            grant_cnt1_r <= 8'd0;
        end else begin
            if (handshake_s && !grant_idx_s) begin
                grant_cnt0_r <= sat_inc8(grant_cnt0_r);
            end else begin
                grant_cnt0_r <= grant_cnt0_r;
            end
            if (handshake_s && grant_idx_s) begin
                grant_cnt1_r <= sat_inc8(grant_cnt1_r);
            end else begin
                grant_cnt1_r <= grant_cnt1_r;
            end
        end
    end

    assign o_grant_cnt0 = grant_cnt0_r;
    assign o_grant_cnt1 = grant_cnt1_r;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed requests, a cycle-level reference model and literal checks.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NB  = 6;
    localparam int LAT = 1;

    typedef struct packed {
        logic [NB-1:0] a;
        logic [NB-1:0] b;
        logic [NB-1:0] op;
    } op_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          i_req0_valid = 1'b0, i_req1_valid = 1'b0;
    logic [NB-1:0] i_req0_a = '0, i_req0_b = '0, i_req0_op = '0;
    logic [NB-1:0] i_req1_a = '0, i_req1_b = '0, i_req1_op = '0;
    logic          o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid, o_busy;
    logic [NB-1:0] o_rsp0_res, o_rsp1_res, o_alu_a, o_alu_b, o_alu_op;
    logic [NB-1:0] alu_res = '0;
    logic [7:0]    grant_cnt0, grant_cnt1;

    always #5 clock = ~clock;

    alu_arbiter #(.N_BITS(NB), .ALU_LAT(LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_req0_valid (i_req0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_a     (i_req0_a),
        .i_req0_b     (i_req0_b),
        .i_req0_op    (i_req0_op),
        .i_req1_valid (i_req1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_a     (i_req1_a),
        .i_req1_b     (i_req1_b),
        .i_req1_op    (i_req1_op),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_res   (o_rsp0_res),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_res   (o_rsp1_res),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .i_alu_res    (alu_res),
        .o_busy       (o_busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .o_grant_cnt0 (grant_cnt0),
        .o_grant_cnt1 (grant_cnt1)
`endif
    );

`ifndef ALU_ARB_STATS_EN
    assign grant_cnt0 = 8'd0;
    assign grant_cnt1 = 8'd0;
`endif

    function automatic logic [NB-1:0] alu_f(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                            input logic [NB-1:0] op);
        case (op)
            NB'(OP_ADD): return a + b;
            NB'(OP_SUB): return a - b;
            NB'(OP_AND): return a & b;
            NB'(OP_OR):  return a | b;
            NB'(OP_XOR): return a ^ b;
            default:     return a;
        endcase
    endfunction

    // External ALU with one registered stage.
    always @(posedge clock) alu_res <= alu_f(o_alu_a, o_alu_b, o_alu_op);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model state
    bit            model_on = 1'b0;
    int            cyc = 0;
    int            free_cyc = 0;
    bit            pend_on = 1'b0;
    int            pend_who = 0;
    int            pend_cyc = 0;
    logic [NB-1:0] pend_res = '0;
    int            last_g = 1;
    logic [NB-1:0] res_hold [2];
    op_t           alu_hold = '0;
    int            gcnt [2];
    bit            hs0 = 1'b0, hs1 = 1'b0;

    int grant_log[$];
    int rsp_res_log[$];
    int rsp_who_log[$];
    int hs_cyc [2];
    int rsp_cyc [2];
    int rsp_cnt [2];

    initial begin
        logic [1:0] vld, rdy, exp_rdy;
        logic       exp_r0, exp_r1;
        int         g;
        op_t        req;
        res_hold[0] = '0; res_hold[1] = '0;
        gcnt[0] = 0; gcnt[1] = 0;
        hs_cyc[0] = 0; hs_cyc[1] = 0; rsp_cyc[0] = 0; rsp_cyc[1] = 0;
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
        forever begin
            @(negedge clock);
            cyc++;
            vld = {i_req1_valid, i_req0_valid};
            rdy = {o_req1_ready, o_req0_ready};
            hs0 = vld[0] && rdy[0];
            hs1 = vld[1] && rdy[1];
            exp_rdy = 2'b00;
            if (model_on) begin
                if (reset || cyc < free_cyc) exp_rdy = 2'b00;
                else if (vld == 2'b11)       exp_rdy = (last_g == 1) ? 2'b01 : 2'b10;
                else                         exp_rdy = vld;
                if (pend_on && cyc == pend_cyc) res_hold[pend_who] = pend_res;
                exp_r0 = pend_on && cyc == pend_cyc && pend_who == 0;
                exp_r1 = pend_on && cyc == pend_cyc && pend_who == 1;
                check("ready", rdy, exp_rdy);
                check("one_ready", rdy == 2'b11, 1'b0);
                check("rsp_valid", {o_rsp1_valid, o_rsp0_valid}, {exp_r1, exp_r0});
                check("rsp0_res", o_rsp0_res, res_hold[0]);
                check("rsp1_res", o_rsp1_res, res_hold[1]);
                check("busy", o_busy, cyc < free_cyc);
                check("alu_ops", {o_alu_a, o_alu_b, o_alu_op}, alu_hold);
`ifdef ALU_ARB_STATS_EN
                check("grant_cnt0", grant_cnt0, gcnt[0]);
                check("grant_cnt1", grant_cnt1, gcnt[1]);
`endif
            end
            if (hs0) begin grant_log.push_back(0); hs_cyc[0] = cyc; end
            if (hs1) begin grant_log.push_back(1); hs_cyc[1] = cyc; end
            if (o_rsp0_valid === 1'b1) begin
                rsp_cnt[0]++; rsp_cyc[0] = cyc;
                rsp_res_log.push_back(int'(o_rsp0_res)); rsp_who_log.push_back(0);
            end
            if (o_rsp1_valid === 1'b1) begin
                rsp_cnt[1]++; rsp_cyc[1] = cyc;
                rsp_res_log.push_back(int'(o_rsp1_res)); rsp_who_log.push_back(1);
            end
            if (reset) begin
                model_on = 1'b1;
                free_cyc = cyc + 1;
                pend_on  = 1'b0;
                last_g   = 1;
                res_hold[0] = '0; res_hold[1] = '0;
                alu_hold = '0;
                gcnt[0] = 0; gcnt[1] = 0;
            end else if (model_on && exp_rdy != 2'b00) begin
                g   = exp_rdy[1] ? 1 : 0;
                req = (g == 1) ? op_t'{i_req1_a, i_req1_b, i_req1_op}
                               : op_t'{i_req0_a, i_req0_b, i_req0_op};
                pend_on  = 1'b1;
                pend_who = g;
                pend_res = alu_f(req.a, req.b, req.op);
                pend_cyc = cyc + LAT + 2;
                free_cyc = cyc + LAT + 3;
                last_g   = g;
                alu_hold = req;
                if (gcnt[g] < 255) gcnt[g]++;
            end
        end
    end

    op_t q0[$];
    op_t q1[$];

    task automatic drive_step(input logic rst_v);
        @(posedge clock);
        #1;
        reset = rst_v;
        if (hs0 && q0.size() > 0) void'(q0.pop_front());
        if (hs1 && q1.size() > 0) void'(q1.pop_front());
        i_req0_valid = (q0.size() > 0);
        i_req1_valid = (q1.size() > 0);
        if (q0.size() > 0) {i_req0_a, i_req0_b, i_req0_op} = q0[0];
        if (q1.size() > 0) {i_req1_a, i_req1_b, i_req1_op} = q1[0];
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            drive_step(1'b0);
            n++;
        end
        check({name, "_timeout"}, n < budget, 1'b1);
        repeat (LAT + 4) drive_step(1'b0);
    endtask

    task automatic clear_logs();
        grant_log.delete(); rsp_res_log.delete(); rsp_who_log.delete();
        rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    int exp_g [6] = '{0, 1, 0, 1, 0, 1};
    int exp_r [6] = '{30, 12, 62, 11, 42, 6};

    initial begin
        // Reset, then a tie in the first cycle out of reset
        repeat (3) drive_step(1'b1);
        q0.push_back(op_t'{6'd1, 6'd1, NB'(OP_ADD)});
        q1.push_back(op_t'{6'd2, 6'd2, NB'(OP_ADD)});
        drive_step(1'b0);
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
        check("rst_rsp_res", {o_rsp1_res, o_rsp0_res}, 12'd0);
        check("rst_alu", {o_alu_a, o_alu_b, o_alu_op}, 18'd0);
        check("rst_tie_ready", {o_req1_ready, o_req0_ready}, 2'b01);
        drain("tie", 50);
        check("tie_grants", grant_log.size(), 2);
        check("tie_first", qget(grant_log, 0), 0);
        check("tie_second", qget(grant_log, 1), 1);
        check("tie_res0", qget(rsp_res_log, 0), 2);
        check("tie_res1", qget(rsp_res_log, 1), 4);
        check("tie_order", qget(rsp_who_log, 1), 1);

        // Single request from requester 0
        clear_logs();
        q0.push_back(op_t'{6'd5, 6'd3, NB'(OP_ADD)});
        drain("single", 50);
        check("single_pulses0", rsp_cnt[0], 1);
        check("single_pulses1", rsp_cnt[1], 0);
        check("single_latency", rsp_cyc[0] - hs_cyc[0], 3);
        check("single_res", o_rsp0_res, 6'd8);

        // Lone requester 1, which also leaves the pointer at 1
        clear_logs();
        q1.push_back(op_t'{6'd7, 6'd2, NB'(OP_SUB)});
        drain("lone1", 50);
        check("lone1_res", o_rsp1_res, 6'd5);
        check("lone1_held0", o_rsp0_res, 6'd8);

        // Fairness under continuous contention
        clear_logs();
        q0.push_back(op_t'{6'd10, 6'd20, NB'(OP_ADD)});
        q0.push_back(op_t'{6'd3,  6'd5,  NB'(OP_SUB)});
        q0.push_back(op_t'{6'd63, 6'd21, NB'(OP_XOR)});
        q1.push_back(op_t'{6'd60, 6'd15, NB'(OP_AND)});
        q1.push_back(op_t'{6'd8,  6'd3,  NB'(OP_OR)});
        q1.push_back(op_t'{6'd40, 6'd30, NB'(OP_ADD)});
        drain("fair", 100);
        check("fair_count", rsp_res_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("fair_grant%0d", i), qget(grant_log, i), exp_g[i]);
            check($sformatf("fair_res%0d", i), qget(rsp_res_log, i), exp_r[i]);
        end

        // Reset during the second EXEC cycle
        clear_logs();
        q0.push_back(op_t'{6'd9, 6'd9, NB'(OP_ADD)});
        drive_step(1'b0);
        drive_step(1'b0);
        drive_step(1'b1);
        drive_step(1'b0);
        #1;
        check("abort_busy", o_busy, 1'b0);
        check("abort_rsp_valid", {o_rsp1_valid, o_rsp0_valid}, 2'b00);
        check("abort_rsp_res", {o_rsp1_res, o_rsp0_res}, 12'd0);
        check("abort_alu", {o_alu_a, o_alu_b, o_alu_op}, 18'd0);
        repeat (LAT + 4) drive_step(1'b0);
        check("abort_no_pulse", rsp_cnt[0] + rsp_cnt[1], 0);
        q1.push_back(op_t'{6'd4, 6'd5, NB'(OP_ADD)});
        drain("after_abort", 50);
        check("after_abort_pulses", rsp_cnt[1], 1);
        check("after_abort_res", o_rsp1_res, 6'd9);

`ifdef ALU_ARB_STATS_EN
        // Counter saturation and reset
        for (int i = 0; i < 300; i++) q1.push_back(op_t'{6'(i), 6'd1, NB'(OP_ADD)});
        drain("stats", 2000);
        check("stats_cnt1", grant_cnt1, 8'd255);
        check("stats_cnt0", grant_cnt0, 8'd0);
        drive_step(1'b1);
        drive_step(1'b0);
        #1;
        check("stats_rst_cnt1", grant_cnt1, 8'd0);
        check("stats_rst_cnt0", grant_cnt0, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL expose parameter N_BITS, default 6, as the width of operands A, B, OP and the result.
REQ-002 The block SHALL expose parameter ALU_LAT, default 1, as the number of clock edges from ALU operand change to valid ALU result (legal 0..7).
REQ-003 The block SHALL have the following ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_req0_valid  in  1  requester 0 has an operation pending
- o_req0_ready  out  1  requester 0 operation accepted this cycle
- i_req0_a, i_req0_b, i_req0_op  in  N_BITS each  requester 0 operands and opcode
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_op  same as requester 0, for requester 1
- o_rsp0_valid  out  1  one-cycle pulse: result for requester 0
- o_rsp0_res  out  N_BITS  requester 0 result
- o_rsp1_valid, o_rsp1_res  same as requester 0, for requester 1
- o_alu_a, o_alu_b, o_alu_op  out  N_BITS each  registered operands to the shared ALU
- i_alu_res  in  N_BITS  ALU result
- o_busy  out  1  high whenever the FSM is not IDLE

Function
REQ-004 The FSM SHALL have states IDLE, EXEC, RESP; the reset state SHALL be IDLE.
REQ-005 In IDLE, with any valid high, it SHALL grant one requester, assert only that ready combinationally, and go to EXEC at the next edge.
REQ-006 A handshake (valid and ready both high) SHALL load o_alu_a/b/op from the granted requester at the following edge.
REQ-007 Ready SHALL be low in EXEC and RESP; at most one ready SHALL be high per cycle.
REQ-008 Single valid requester SHALL always be granted; on simultaneous valid, the requester not granted last SHALL win.
REQ-009 The last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-010 EXEC SHALL last exactly ALU_LAT+1 cycles, tracked by a down-counter, then go to RESP.
REQ-011 At the EXEC-to-RESP edge, i_alu_res SHALL be captured into the granted requester's o_rspN_res.
REQ-012 In RESP, o_rspN_valid SHALL be high for the granted requester only; the FSM SHALL return to IDLE next edge.
REQ-013 Handshake in cycle t SHALL give the response pulse in cycle t+ALU_LAT+2; the next handshake is possible no earlier than t+ALU_LAT+3.
REQ-014 o_rspN_res SHALL hold its value until the next response to that requester.
REQ-015 o_alu_a/b/op SHALL hold their last values outside EXEC.
REQ-016 The block SHALL NOT check valid stability; requesters hold valid and operands until ready.

Reset
REQ-017 Reset SHALL force: state IDLE, all ready/valid outputs 0, o_busy 0, o_rspN_res 0, o_alu_* 0, counter 0, pointer 1.
REQ-018 Reset during EXEC or RESP SHALL abort the operation with no response pulse.

Configuration
REQ-019 With ALU_ARB_STATS_EN defined, the block SHALL add outputs o_grant_cnt0 and o_grant_cnt1 (8 bits each).
REQ-020 Each counter SHALL increment on its requester's handshake, saturate at 255, and reset to 0.
REQ-021 Without ALU_ARB_STATS_EN, these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-022 Package alu_pkg SHALL hold the default N_BITS, the ALU opcode constants, and the FSM state type for IDLE/EXEC/RESP.
REQ-023 Grant selection SHALL be a sub-module rr_arb2 (2-way round robin with pointer); FSM, counter and registers stay in alu_arbiter.

Verification
REQ-024 The bench SHALL use ALU_LAT=1 and an ALU model with a registered output.
REQ-025 Single request: req0 A=5, B=3, op=ADD, handshake in cycle t -> o_rsp0_valid in t+3 only, o_rsp0_res=8, o_rsp1_valid stays 0.
REQ-026 Tie: both valid in the first cycle after reset (req0 ADD 1,1; req1 ADD 2,2) -> req0 served first (res 2), then req1 (res 4); ready never high for both.
REQ-027 Fairness: both valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1; each response pulse is one cycle.
REQ-028 Reset mid-op: reset asserted in second EXEC cycle -> no rsp pulse, all outputs 0, o_busy 0; next request served normally.
REQ-029 With ALU_ARB_STATS_EN: 300 req1 handshakes -> o_grant_cnt1=255, o_grant_cnt0=0; reset -> both 0.
